// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one SRAM between instruction fetch and MEM-stage data access; data wins.
// Define MEM_WR_HOLD_EN to add a WR_HOLD cycle after the write strobe.
module mem_arbiter (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] if_addr,
    output logic [15:0] if_inst,
    input  logic        mem_req,
    input  logic        mem_we,
    input  logic [15:0] mem_addr,
    input  logic [15:0] mem_wdata,
    output logic [15:0] mem_rdata,
    output logic        mem_done,
    output logic        stall_req,
    output logic [15:0] ram_addr,
    output logic [15:0] ram_dout,
    output logic        ram_dout_en,
    input  logic [15:0] ram_din,
    output logic        ram_oe_n,
    output logic        ram_we_n
);
    typedef enum logic [2:0] {
        FETCH, D_RD, WR_SETUP, WR_PULSE
`ifdef MEM_WR_HOLD_EN
        , WR_HOLD
`endif
    } state_t;
    state_t      state_q, state_d;
    logic        served_q;
    logic [15:0] if_inst_q, mem_rdata_q;
    assign if_inst   = if_inst_q;
    assign mem_rdata = mem_rdata_q;
    assign ram_dout  = mem_wdata;
    assign stall_req = !rst && (state_q != FETCH || (mem_req && !served_q));
    always_comb begin
        state_d     = state_q;
        ram_addr    = mem_addr;
        ram_oe_n    = 1'b1;
        ram_we_n    = 1'b1;
        ram_dout_en = 1'b0;
        mem_done    = 1'b0;
        case (state_q)
            FETCH: begin
                ram_addr = if_addr;
                ram_oe_n = 1'b0;
                if (mem_req && !served_q) state_d = mem_we ? WR_SETUP : D_RD;
            end
            D_RD: begin
                ram_oe_n = 1'b0;
                mem_done = 1'b1;
                state_d  = FETCH;
            end
            WR_SETUP: begin
                ram_dout_en = 1'b1;
                state_d     = WR_PULSE;
            end
            WR_PULSE: begin
                ram_dout_en = 1'b1;
                ram_we_n    = 1'b0;
`ifdef MEM_WR_HOLD_EN
                state_d     = WR_HOLD;
`else
                mem_done    = 1'b1;
                state_d     = FETCH;
`endif
            end
`ifdef MEM_WR_HOLD_EN
            WR_HOLD: begin
                ram_dout_en = 1'b1;
                mem_done    = 1'b1;
                state_d     = FETCH;
            end
`endif
            default: state_d = FETCH;
        endcase
        // reset forces the bus quiet immediately, even mid-strobe
        if (rst) begin
            ram_oe_n    = 1'b1;
            ram_we_n    = 1'b1;
            ram_dout_en = 1'b0;
            mem_done    = 1'b0;
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= FETCH;
            served_q    <= 1'b0;
            if_inst_q   <= 16'h0000;
            mem_rdata_q <= 16'h0000;
        end else begin
            state_q  <= state_d;
            served_q <= mem_done;
            if (state_q == FETCH) if_inst_q <= ram_din;
            if (state_q == D_RD) mem_rdata_q <= ram_din;
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: per-cycle vector table for mem_arbiter plus a hand-written abort-free read check.
module tb_mem_arbiter;
    logic        clk = 1'b0;
    logic        rst, mem_req, mem_we, mem_done, stall_req, ram_dout_en, ram_oe_n, ram_we_n;
    logic [15:0] if_addr, if_inst, mem_addr, mem_wdata, mem_rdata, ram_addr, ram_dout, ram_din;
    int          checks = 0;
    int          failures = 0;

    mem_arbiter dut (
        .clk(clk), .rst(rst), .if_addr(if_addr), .if_inst(if_inst),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_done(mem_done), .stall_req(stall_req),
        .ram_addr(ram_addr), .ram_dout(ram_dout), .ram_dout_en(ram_dout_en),
        .ram_din(ram_din), .ram_oe_n(ram_oe_n), .ram_we_n(ram_we_n)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst, req, we;
        logic [15:0] addr, wdata, ifa, din;
        logic        stall, done, we_n, oe_n, den;
        logic [15:0] raddr, ifi, rdata;
    } vec_t;
    vec_t v[$];

    function automatic vec_t mk(logic r, logic q, logic w, logic [15:0] a, logic [15:0] wd,
                                logic [15:0] ia, logic [15:0] d, logic s, logic dn,
                                logic wn, logic on, logic de, logic [15:0] ra,
                                logic [15:0] ii, logic [15:0] rd);
        vec_t t;
        t.rst = r; t.req = q; t.we = w; t.addr = a; t.wdata = wd; t.ifa = ia; t.din = d;
        t.stall = s; t.done = dn; t.we_n = wn; t.oe_n = on; t.den = de;
        t.raddr = ra; t.ifi = ii; t.rdata = rd;
        return t;
    endfunction

    task automatic chk(string name, int idx, logic [15:0] act, logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s step %0d: got %h expected %h", name, idx, act, exp);
        end
    endtask

    task automatic drive(logic r, logic q, logic w, logic [15:0] a, logic [15:0] wd,
                         logic [15:0] ia, logic [15:0] d);
        rst = r; mem_req = q; mem_we = w; mem_addr = a; mem_wdata = wd; if_addr = ia; ram_din = d;
    endtask

    initial begin
        drive(1, 0, 0, 16'h0, 16'h0, 16'h0004, 16'h6801);
        @(negedge clk);
        //      rst req we addr      wdata     ifa       din       stl dn wn on de raddr     ifi       rdata
        v.push_back(mk(1, 0, 0, 16'h0000, 16'h0000, 16'h0004, 16'h6801, 0, 0, 1, 1, 0, 16'h0004, 16'h0000, 16'h0000));
        v.push_back(mk(0, 0, 0, 16'h0000, 16'h0000, 16'h0004, 16'h6801, 0, 0, 1, 0, 0, 16'h0004, 16'h0000, 16'h0000));
        v.push_back(mk(0, 0, 0, 16'h0000, 16'h0000, 16'h0006, 16'h6802, 0, 0, 1, 0, 0, 16'h0006, 16'h6801, 16'h0000));
        v.push_back(mk(0, 1, 0, 16'h8000, 16'h0000, 16'h0008, 16'h1111, 1, 0, 1, 0, 0, 16'h0008, 16'h6802, 16'h0000));
        v.push_back(mk(0, 1, 0, 16'h8000, 16'h0000, 16'h0008, 16'h1234, 1, 1, 1, 0, 0, 16'h8000, 16'h1111, 16'h0000));
        v.push_back(mk(0, 1, 0, 16'h8000, 16'h0000, 16'h0008, 16'h2222, 0, 0, 1, 0, 0, 16'h0008, 16'h1111, 16'h1234));
        v.push_back(mk(0, 1, 1, 16'h8001, 16'hBEEF, 16'h000A, 16'h3333, 1, 0, 1, 0, 0, 16'h000A, 16'h2222, 16'h1234));
        v.push_back(mk(0, 1, 1, 16'h8001, 16'hBEEF, 16'h000A, 16'h3333, 1, 0, 1, 1, 1, 16'h8001, 16'h3333, 16'h1234));
`ifdef MEM_WR_HOLD_EN
        v.push_back(mk(0, 1, 1, 16'h8001, 16'hBEEF, 16'h000A, 16'h3333, 1, 0, 0, 1, 1, 16'h8001, 16'h3333, 16'h1234));
        v.push_back(mk(0, 1, 1, 16'h8001, 16'hBEEF, 16'h000A, 16'h3333, 1, 1, 1, 1, 1, 16'h8001, 16'h3333, 16'h1234));
`else
        v.push_back(mk(0, 1, 1, 16'h8001, 16'hBEEF, 16'h000A, 16'h3333, 1, 1, 0, 1, 1, 16'h8001, 16'h3333, 16'h1234));
`endif
        v.push_back(mk(0, 1, 1, 16'h8001, 16'hBEEF, 16'h000A, 16'h4444, 0, 0, 1, 0, 0, 16'h000A, 16'h3333, 16'h1234));
        v.push_back(mk(0, 0, 0, 16'h0000, 16'h0000, 16'h000A, 16'h4444, 0, 0, 1, 0, 0, 16'h000A, 16'h4444, 16'h1234));
        v.push_back(mk(0, 1, 1, 16'h9000, 16'h5555, 16'h000C, 16'h6666, 1, 0, 1, 0, 0, 16'h000C, 16'h4444, 16'h1234));
        v.push_back(mk(0, 1, 1, 16'h9000, 16'h5555, 16'h000C, 16'h6666, 1, 0, 1, 1, 1, 16'h9000, 16'h6666, 16'h1234));
        v.push_back(mk(1, 1, 1, 16'h9000, 16'h5555, 16'h000C, 16'h6666, 0, 0, 1, 1, 0, 16'h9000, 16'h6666, 16'h1234));
        v.push_back(mk(0, 0, 0, 16'h0000, 16'h0000, 16'h000C, 16'h7777, 0, 0, 1, 0, 0, 16'h000C, 16'h0000, 16'h0000));
        foreach (v[i]) begin
            drive(v[i].rst, v[i].req, v[i].we, v[i].addr, v[i].wdata, v[i].ifa, v[i].din);
            #1;
            chk("stall_req", i, {15'd0, stall_req}, {15'd0, v[i].stall});
            chk("mem_done", i, {15'd0, mem_done}, {15'd0, v[i].done});
            chk("ram_we_n", i, {15'd0, ram_we_n}, {15'd0, v[i].we_n});
            chk("ram_oe_n", i, {15'd0, ram_oe_n}, {15'd0, v[i].oe_n});
            chk("ram_dout_en", i, {15'd0, ram_dout_en}, {15'd0, v[i].den});
            if (!v[i].rst) chk("ram_addr", i, ram_addr, v[i].raddr);
            if (v[i].den) chk("ram_dout", i, ram_dout, v[i].wdata);
            chk("if_inst", i, if_inst, v[i].ifi);
            chk("mem_rdata", i, mem_rdata, v[i].rdata);
            @(negedge clk);
        end
        // read request withdrawn after it was accepted must still complete
        drive(0, 1, 0, 16'h8100, 16'h0000, 16'h000E, 16'h8888);
        #1 chk("abort_stall0", 100, {15'd0, stall_req}, 16'd1);
        @(negedge clk);
        drive(0, 0, 0, 16'h8100, 16'h0000, 16'h000E, 16'h9999);
        #1 chk("abort_done", 101, {15'd0, mem_done}, 16'd1);
        chk("abort_stall1", 101, {15'd0, stall_req}, 16'd1);
        chk("abort_addr", 101, ram_addr, 16'h8100);
        @(negedge clk);
        #1 chk("abort_stall2", 102, {15'd0, stall_req}, 16'd0);
        chk("abort_rdata", 102, mem_rdata, 16'h9999);
        chk("abort_ifinst", 102, if_inst, 16'h8888);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL have one clock, clk, and a synchronous, active-high reset, rst; port list:
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 if_addr  input  16  fetch address, driven by pc.
REQ-005 if_inst  output  16  registered fetched instruction.
REQ-006 mem_req  input  1  MEM-stage access request, held until served.
REQ-007 mem_we  input  1  1 = write, 0 = read; valid with mem_req.
REQ-008 mem_addr  input  16  data address.
REQ-009 mem_wdata  input  16  write data.
REQ-010 mem_rdata  output  16  registered read data.
REQ-011 mem_done  output  1  one-cycle pulse, data access completes at this edge.
REQ-012 stall_req  output  1  1 = pc and pipeline hold this cycle.
REQ-013 ram_addr  output  16  SRAM address.
REQ-014 ram_dout  output  16  SRAM write data; ram_dout_en  output  1  drive data bus; ram_din  input  16  SRAM read data.
REQ-015 ram_oe_n  output  1  SRAM output enable, active-low; ram_we_n  output  1  SRAM write enable, active-low.

Function
REQ-016 Single SRAM SHALL be shared between instruction fetch and MEM-stage data access; data access has priority.
REQ-017 States SHALL be FETCH, D_RD, WR_SETUP, WR_PULSE (plus WR_HOLD per REQ-031); SRAM controls are decoded from state only.
REQ-018 FETCH: ram_addr=if_addr, ram_oe_n=0, ram_we_n=1, ram_dout_en=0; if_inst <= ram_din at every edge leaving or remaining in FETCH.
REQ-019 D_RD: ram_addr=mem_addr, ram_oe_n=0; at the edge, mem_rdata <= ram_din, mem_done=1 during the cycle, next state FETCH.
REQ-020 WR_SETUP: ram_addr=mem_addr, ram_dout=mem_wdata, ram_dout_en=1, ram_oe_n=1, ram_we_n=1; next WR_PULSE.
REQ-021 WR_PULSE: as WR_SETUP but ram_we_n=0; mem_done=1; next FETCH (or WR_HOLD per REQ-031).
REQ-022 Internal served flag SHALL set at the edge where mem_done=1 and clear at the next edge; FETCH with mem_req=1 and served=0 starts D_RD (mem_we=0) or WR_SETUP (mem_we=1); with served=1 the request is ignored.
REQ-023 stall_req SHALL equal (state != FETCH) OR (mem_req AND NOT served), combinationally.
REQ-024 Latency: read access costs 2 stall cycles, write 3; no stall without mem_req.
REQ-025 if_inst and mem_rdata SHALL hold their values in all cycles not listed as updating them.
REQ-026 mem_req deasserted mid-sequence SHALL NOT abort the sequence; access completes as started.

Reset
REQ-027 While rst=1: ram_we_n=1, ram_oe_n=1, ram_dout_en=0, stall_req=0, mem_done=0, combinationally.
REQ-028 At the edge with rst=1: state=FETCH, served=0, if_inst=16'h0000, mem_rdata=16'h0000.
REQ-029 Reset during WR_PULSE SHALL deassert ram_we_n in that same cycle; the write is not reported done.

Configuration
REQ-030 Macro MEM_WR_HOLD_EN SHALL select write timing.
REQ-031 Defined: WR_PULSE goes to WR_HOLD (ram_we_n=1, data still driven, ram_dout_en=1), mem_done moves to WR_HOLD, write costs 4 stall cycles; undefined: no WR_HOLD state, behaviour per REQ-021.

Verification
REQ-032 Reset, if_addr=0x0004, ram_din=0x6801, no mem_req -> stall_req=0 every cycle, if_inst=0x6801 after first edge.
REQ-033 FETCH, mem_req=1, mem_we=0, mem_addr=0x8000, ram_din=0x1234 -> stall_req=1 two cycles, mem_done pulse in D_RD, mem_rdata=0x1234, next cycle stall_req=0 with mem_req still 1.
REQ-034 mem_req=1, mem_we=1, mem_addr=0x8001, mem_wdata=0xBEEF -> ram_we_n low exactly one cycle with ram_addr=0x8001, ram_dout=0xBEEF, stall_req=1 three cycles.
REQ-035 Back-to-back: read completes, MEM advances, new write request next cycle -> one FETCH cycle with stall_req=0, then write sequence starts.
REQ-036 rst=1 during WR_PULSE -> ram_we_n=1 same cycle, mem_done=0, state FETCH after edge.
REQ-037 Build with MEM_WR_HOLD_EN, repeat REQ-034 -> ram_dout_en high three cycles, mem_done in WR_HOLD, stall_req=1 four cycles.
